// File: rtl/latency_stats_pkg.sv
// Shared widths, stats record, saturating helpers and FSM encoding for latency_stats.
// DW, CNT_W and SUM_W are fixed here so the stats record and helpers have one definition.
package latency_stats_pkg;

  localparam int unsigned DW    = 64;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned SUM_W = 64;

  typedef struct packed {
    logic [DW-1:0]    min;
    logic [DW-1:0]    max;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] neg;
  } lat_stats_t;

  localparam lat_stats_t STATS_RESET = '{min: '1, max: '0, sum: '0, count: '0, neg: '0};

  typedef enum logic {StIdle, StDump} lat_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                               input logic [DW-1:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + (SUM_W + 1)'(b);
    return s[SUM_W] ? '1 : s[SUM_W-1:0];
  endfunction

endpackage

// File: rtl/lat_hist_bank.sv
// Live and shadow histogram bins: saturating increment, capture into shadow, optional clear,
// and a read mux on the frozen shadow copy.
module lat_hist_bank
  import latency_stats_pkg::*;
#(
  parameter int unsigned BINS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  input  logic [$clog2(BINS)-1:0] inc_bin,
  input  logic                    capture,
  input  logic                    clear,
  input  logic [$clog2(BINS)-1:0] rd_bin,
  output logic [CNT_W-1:0]        rd_count
);

  localparam int unsigned BW = $clog2(BINS);

  logic [CNT_W-1:0] live_q   [BINS];
  logic [CNT_W-1:0] live_d   [BINS];
  logic [CNT_W-1:0] shadow_q [BINS];

  // The same-cycle sample lands on top of the cleared base so it is never lost.
  always_comb begin
    for (int i = 0; i < BINS; i++) begin
      live_d[i] = (capture && clear) ? '0 : live_q[i];
      if (inc && (inc_bin == BW'(i))) begin
        live_d[i] = sat_inc(live_d[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BINS; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BINS; i++) begin
        live_q[i] <= live_d[i];
        if (capture) begin
          shadow_q[i] <= live_q[i];
        end
      end
    end
  end

  assign rd_count = shadow_q[rd_bin];

endmodule

// File: rtl/latency_stats.sv
// Latency delta statistics: min/max/sum/count/negative count plus a histogram, with an atomic
// snapshot that freezes the scalars and streams the frozen histogram over valid/ready.
module latency_stats
  import latency_stats_pkg::*;
#(
  parameter int unsigned BINS      = 16,
  parameter int unsigned BIN_SHIFT = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    delta_valid,
  input  logic [DW-1:0]           delta,
  input  logic                    snap_req,
  input  logic                    snap_clear,
  output logic                    snap_busy,
  output logic                    snap_valid,
  output logic [DW-1:0]           snap_min,
  output logic [DW-1:0]           snap_max,
  output logic [SUM_W-1:0]        snap_sum,
  output logic [CNT_W-1:0]        snap_count,
  output logic [CNT_W-1:0]        snap_neg,
  output logic                    hist_valid,
  input  logic                    hist_ready,
  output logic [$clog2(BINS)-1:0] hist_bin,
  output logic [CNT_W-1:0]        hist_count,
  output logic                    hist_last
);

  localparam int unsigned BW = $clog2(BINS);

  lat_state_e    state_q, state_d;
  logic [BW-1:0] bin_q, bin_d;
  lat_stats_t    live_q, live_d, snap_q;
  logic          snap_valid_q;

  logic          accept;
  logic          sample_pos;
  logic          sample_neg;
  logic [DW-1:0] shifted;
  logic [BW-1:0] sample_bin;

  assign accept     = (state_q == StIdle) && snap_req;
  assign sample_pos = delta_valid && !delta[DW-1];
  assign sample_neg = delta_valid && delta[DW-1];

  always_comb begin
    shifted = delta >> BIN_SHIFT;
    if (shifted > DW'(BINS - 1)) begin
      sample_bin = BW'(BINS - 1);
    end else begin
      sample_bin = shifted[BW-1:0];
    end
  end

  always_comb begin
    live_d = (accept && snap_clear) ? STATS_RESET : live_q;
    if (sample_pos) begin
      if (delta < live_d.min) live_d.min = delta;
      if (delta > live_d.max) live_d.max = delta;
      live_d.sum   = sat_add(live_d.sum, delta);
      live_d.count = sat_inc(live_d.count);
    end
    if (sample_neg) begin
      live_d.neg = sat_inc(live_d.neg);
    end
  end

  // Capture reads live_q, so the sample arriving with the request is excluded.
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q       <= STATS_RESET;
      snap_q       <= STATS_RESET;
      snap_valid_q <= 1'b0;
    end else begin
      live_q       <= live_d;
      snap_valid_q <= accept;
      if (accept) begin
        snap_q <= live_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    unique case (state_q)
      StIdle: begin
        bin_d = '0;
        if (snap_req) state_d = StDump;
      end
      StDump: begin
        if (hist_ready) begin
          bin_d = bin_q + BW'(1);
          if (bin_q == BW'(BINS - 1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    hist_valid = (state_q == StDump);
    snap_busy  = (state_q == StDump);
    hist_last  = (state_q == StDump) && (bin_q == BW'(BINS - 1));
    hist_bin   = bin_q;
  end

  assign snap_valid = snap_valid_q;
  assign snap_min   = snap_q.min;
  assign snap_max   = snap_q.max;
  assign snap_sum   = snap_q.sum;
  assign snap_count = snap_q.count;
  assign snap_neg   = snap_q.neg;

  lat_hist_bank #(
    .BINS(BINS)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .inc     (sample_pos),
    .inc_bin (sample_bin),
    .capture (accept),
    .clear   (snap_clear),
    .rd_bin  (bin_q),
    .rd_count(hist_count)
  );

endmodule

// File: tb/tb_latency_stats.sv
// Bench for latency_stats: table-driven snapshot vectors, corner-case sequences and randomized
// traffic checked against a sample-list reference model.
module tb_latency_stats;

  logic        clk;
  logic        rst;
  logic        delta_valid;
  logic [63:0] delta;
  logic        snap_req;
  logic        snap_clear;
  logic        snap_busy;
  logic        snap_valid;
  logic [63:0] snap_min;
  logic [63:0] snap_max;
  logic [63:0] snap_sum;
  logic [31:0] snap_count;
  logic [31:0] snap_neg;
  logic        hist_valid;
  logic        hist_ready;
  logic [3:0]  hist_bin;
  logic [31:0] hist_count;
  logic        hist_last;

  latency_stats #(
    .BINS     (16),
    .BIN_SHIFT(6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .delta_valid(delta_valid),
    .delta      (delta),
    .snap_req   (snap_req),
    .snap_clear (snap_clear),
    .snap_busy  (snap_busy),
    .snap_valid (snap_valid),
    .snap_min   (snap_min),
    .snap_max   (snap_max),
    .snap_sum   (snap_sum),
    .snap_count (snap_count),
    .snap_neg   (snap_neg),
    .hist_valid (hist_valid),
    .hist_ready (hist_ready),
    .hist_bin   (hist_bin),
    .hist_count (hist_count),
    .hist_last  (hist_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: list of non-negative samples since the last clear, plus a negative tally.
  logic [63:0] samples [$];
  int          neg_seen;

  logic [63:0] e_min, e_max, e_sum;
  logic [31:0] e_cnt, e_neg;
  logic [31:0] e_bins [16];

  typedef struct {
    int          n;
    logic [63:0] d [3];
    logic [63:0] t_min, t_max, t_sum;
    logic [31:0] t_cnt, t_neg;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_push(input logic [63:0] d);
    if (d[63]) neg_seen++;
    else samples.push_back(d);
  endtask

  task automatic model_clear();
    samples.delete();
    neg_seen = 0;
  endtask

  task automatic model_expect();
    logic [127:0] acc;
    logic [63:0]  b;
    e_min = '1;
    e_max = '0;
    acc   = '0;
    e_cnt = '0;
    for (int i = 0; i < 16; i++) e_bins[i] = '0;
    foreach (samples[i]) begin
      if (samples[i] < e_min) e_min = samples[i];
      if (samples[i] > e_max) e_max = samples[i];
      acc = acc + {64'd0, samples[i]};
      e_cnt++;
      b = samples[i] / 64;
      if (b > 15) b = 15;
      e_bins[b[3:0]]++;
    end
    e_sum = (acc > {64'd0, {64{1'b1}}}) ? {64{1'b1}} : acc[63:0];
    e_neg = 32'(neg_seen);
  endtask

  function automatic logic [63:0] rand_delta();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 6) return 64'($urandom_range(0, 1200));
    if (r < 8) return 64'($urandom_range(0, 100000));
    if (r == 8) return {32'hFFFF_FFFF, 32'($urandom)};
    return 64'(64 * $urandom_range(1, 16) - 1);
  endfunction

  task automatic drive_sample(input logic [63:0] d);
    delta_valid = 1'b1;
    delta       = d;
    @(posedge clk);
    model_push(d);
    #1;
    delta_valid = 1'b0;
  endtask

  task automatic do_snap(input bit clr, input bit with_s, input logic [63:0] d);
    model_expect();
    snap_req    = 1'b1;
    snap_clear  = clr;
    delta_valid = with_s;
    delta       = d;
    @(posedge clk);
    if (clr) model_clear();
    if (with_s) model_push(d);
    #1;
    snap_req    = 1'b0;
    snap_clear  = 1'b0;
    delta_valid = 1'b0;
    chk("snap_valid_pulse", 64'(snap_valid), 64'd1);
    chk("snap_busy_rise", 64'(snap_busy), 64'd1);
    chk("snap_min", snap_min, e_min);
    chk("snap_max", snap_max, e_max);
    chk("snap_sum", snap_sum, e_sum);
    chk("snap_count", 64'(snap_count), 64'(e_cnt));
    chk("snap_neg", 64'(snap_neg), 64'(e_neg));
  endtask

  // ready_mode: 0 alternate, 1 random, 2 always ready.
  task automatic drain(input int ready_mode, input bit inject, input int snapreq_at);
    int          idx;
    int          cyc;
    bit          acc;
    logic [63:0] act, exp;
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 400) begin
      case (ready_mode)
        0:       hist_ready = (cyc % 2 == 0);
        1:       hist_ready = 1'($urandom_range(0, 1));
        default: hist_ready = 1'b1;
      endcase
      if (inject) begin
        delta_valid = 1'($urandom_range(0, 1));
        delta       = rand_delta();
      end
      snap_req   = (cyc == snapreq_at);
      snap_clear = (cyc == snapreq_at);
      act = {26'd0, hist_valid, hist_last, hist_bin, hist_count};
      exp = {26'd0, 1'b1, (idx == 15), 4'(idx), e_bins[idx]};
      chk($sformatf("beat%0d", idx), act, exp);
      @(posedge clk);
      acc = hist_ready;
      if (delta_valid) model_push(delta);
      #1;
      delta_valid = 1'b0;
      snap_req    = 1'b0;
      snap_clear  = 1'b0;
      if (acc) idx++;
      cyc++;
      if (cyc == 1) chk("snap_valid_fall", 64'(snap_valid), 64'd0);
    end
    hist_ready = 1'b0;
    if (idx < 16) chk("drain_timeout", 64'(idx), 64'd16);
    chk("dump_end_valid", 64'(hist_valid), 64'd0);
    chk("dump_end_busy", 64'(snap_busy), 64'd0);
  endtask

  task automatic chk_table(input int k);
    chk($sformatf("tbl%0d_min", k), snap_min, tbl[k].t_min);
    chk($sformatf("tbl%0d_max", k), snap_max, tbl[k].t_max);
    chk($sformatf("tbl%0d_sum", k), snap_sum, tbl[k].t_sum);
    chk($sformatf("tbl%0d_cnt", k), 64'(snap_count), 64'(tbl[k].t_cnt));
    chk($sformatf("tbl%0d_neg", k), 64'(snap_neg), 64'(tbl[k].t_neg));
  endtask

  initial begin
    tbl[0] = '{n: 3, d: '{64'd100, 64'd50, 64'd300}, t_min: 64'd50, t_max: 64'd300,
               t_sum: 64'd450, t_cnt: 32'd3, t_neg: 32'd0};
    tbl[1] = '{n: 1, d: '{64'hFFFF_FFFF_FFFF_FF00, 64'd0, 64'd0}, t_min: {64{1'b1}},
               t_max: 64'd0, t_sum: 64'd0, t_cnt: 32'd0, t_neg: 32'd1};
    tbl[2] = '{n: 1, d: '{64'd5000, 64'd0, 64'd0}, t_min: 64'd5000, t_max: 64'd5000,
               t_sum: 64'd5000, t_cnt: 32'd1, t_neg: 32'd0};
    tbl[3] = '{n: 3, d: '{64'd0, 64'd63, 64'd64}, t_min: 64'd0, t_max: 64'd64,
               t_sum: 64'd127, t_cnt: 32'd3, t_neg: 32'd0};
    tbl[4] = '{n: 3, d: '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
               64'h7FFF_FFFF_FFFF_FFFF}, t_min: 64'h7FFF_FFFF_FFFF_FFFF,
               t_max: 64'h7FFF_FFFF_FFFF_FFFF, t_sum: {64{1'b1}}, t_cnt: 32'd3, t_neg: 32'd0};

    rst         = 1'b1;
    delta_valid = 1'b0;
    delta       = '0;
    snap_req    = 1'b0;
    snap_clear  = 1'b0;
    hist_ready  = 1'b0;
    neg_seen    = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_min", snap_min, {64{1'b1}});
    chk("rst_outs", {snap_max[31:0], snap_sum[31:0]}, 64'd0);
    chk("rst_cnt_neg", {snap_count, snap_neg}, 64'd0);
    chk("rst_flags", 64'({snap_busy, snap_valid, hist_valid, hist_last}), 64'd0);

    chk("sat_inc_max", 64'(latency_stats_pkg::sat_inc(32'hFFFF_FFFF)), 64'h0000_0000_FFFF_FFFF);
    chk("sat_inc_mid", 64'(latency_stats_pkg::sat_inc(32'd41)), 64'd42);
    chk("sat_add_max", latency_stats_pkg::sat_add(64'hFFFF_FFFF_FFFF_FFF0, 64'd100),
        {64{1'b1}});

    // Table vectors: each entry stands alone because every snapshot clears.
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < tbl[k].n; j++) drive_sample(tbl[k].d[j]);
      do_snap(1'b1, 1'b0, 64'd0);
      chk_table(k);
      drain(2, 1'b0, -1);
      chk_table(k);
    end

    // Same-cycle sample with clear goes to the new epoch only.
    drive_sample(64'd3);
    drive_sample(64'd9);
    do_snap(1'b1, 1'b1, 64'd7);
    chk("clr_excl_cnt", 64'(snap_count), 64'd2);
    drain(2, 1'b0, -1);
    do_snap(1'b1, 1'b0, 64'd0);
    chk("clr_next_cnt", 64'(snap_count), 64'd1);
    chk("clr_next_mm", {snap_min[31:0], snap_max[31:0]}, {32'd7, 32'd7});

    // Alternating ready with an ignored snapshot request mid-dump.
    drain(0, 1'b0, 3);

    // Randomized rounds; the first never clears, so a wrongly honoured mid-dump clear shows up.
    for (int r = 0; r < 10; r++) begin
      int unsigned n;
      n = $urandom_range(0, 20);
      for (int i = 0; i < int'(n); i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end else begin
          drive_sample(rand_delta());
        end
      end
      do_snap((r == 0) ? 1'b0 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_delta());
      drain(1, 1'b1, int'($urandom_range(0, 12)));
    end

    // Reset in the middle of a dump.
    drive_sample(64'd200);
    do_snap(1'b0, 1'b0, 64'd0);
    hist_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    hist_ready = 1'b0;
    model_clear();
    chk("mid_rst_valid", 64'(hist_valid), 64'd0);
    chk("mid_rst_busy", 64'(snap_busy), 64'd0);
    chk("mid_rst_min", snap_min, {64{1'b1}});
    do_snap(1'b0, 1'b0, 64'd0);
    drain(2, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
